// File: rtl/fast_keypoint_stream.sv
// fast_keypoint_stream
// Raster-stream corner detector. Two line buffers plus a sliding window
// history form a 3x3 neighbourhood per pixel beat. A two-stage pipeline
// runs a brighter/darker ring test against a threshold latched at start of
// frame, then looks for a circular arc of ARC_LEN set ring bits.
// Keypoints (centre coordinates and polarity) come out two cycles after the
// beat that completes their window. frame_done pulses with the result of
// the frame's last beat.
module fast_keypoint_stream #(
    parameter int PIX_W   = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ARC_LEN = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] threshold,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             kp_valid,
    output logic             kp_bright,
    output logic             kp_dark,
    output logic [X_W-1:0]   kp_x,
    output logic [Y_W-1:0]   kp_y,
    output logic             frame_done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt;
    logic [PIX_W-1:0] thr_q;

    logic             accept;     // beat is taken into the frame
    logic             sof_beat;   // qualified start of frame
    logic             beat_last;  // accepted beat at the final pixel
    logic [X_W-1:0]   bx;         // coordinates of the current beat
    logic [Y_W-1:0]   by;

    // line buffers: lb_mid holds row y-1, lb_top holds row y-2
    logic [PIX_W-1:0] lb_mid [IMG_W];
    logic [PIX_W-1:0] lb_top [IMG_W];
    // the two previously seen columns; with the incoming column they form
    // the 3x3 window. hist[r][0] is column x-2, hist[r][1] is column x-1.
    logic [PIX_W-1:0] hist [3][2];
    logic [PIX_W-1:0] col  [3];
    logic [PIX_W-1:0] ring [8];
    logic [PIX_W-1:0] centre;
    logic [7:0]       bright_c, dark_c;
    logic             tok0;

    // pipeline stage registers
    logic [2:1]       vld_pipe;
    logic [2:1]       lst_pipe;
    logic [7:0]       bright_q, dark_q;
    logic [X_W-1:0]   cx_q;
    logic [Y_W-1:0]   cy_q;
    logic             hit_b, hit_d;
    logic             bright_hit, dark_hit;

    // circular run of ARC_LEN set bits, wrapping from index 7 back to 0
    function automatic logic arc_found(input logic [7:0] v);
        logic [14:0] vv;
        logic        hit;
        logic        run;
        vv  = {v[6:0], v};
        hit = 1'b0;
        for (int s = 0; s < 8; s++) begin
            run = 1'b1;
            for (int k = 0; k < ARC_LEN; k++) run = run & vv[s + k];
            hit = hit | run;
        end
        return hit;
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: sof restarts from anywhere, the last pixel ends the frame
    always_comb begin
        state_nxt = state;
        if (sof_beat)       state_nxt = ACTIVE;
        else if (beat_last) state_nxt = IDLE;
    end

    // FSM outputs: beat qualification and beat position (sof forces 0,0)
    always_comb begin
        sof_beat  = in_valid && in_sof;
        accept    = in_valid && (in_sof || state == ACTIVE);
        bx        = in_sof ? '0 : x_cnt;
        by        = in_sof ? '0 : y_cnt;
        beat_last = accept && (bx == X_W'(IMG_W - 1)) && (by == Y_W'(IMG_H - 1));
    end

    // raster counters and threshold latch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            thr_q <= '0;
        end else begin
            if (sof_beat) thr_q <= threshold;
            if (accept) begin
                if (beat_last) begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end else if (bx == X_W'(IMG_W - 1)) begin
                    x_cnt <= '0;
                    y_cnt <= by + Y_W'(1);
                end else begin
                    x_cnt <= bx + X_W'(1);
                    y_cnt <= by;
                end
            end
        end
    end

    // line buffers and window history; contents are rewritten before use
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[bx] <= lb_mid[bx];
            lb_mid[bx] <= in_pixel;
            for (int r = 0; r < 3; r++) begin
                hist[r][0] <= hist[r][1];
                hist[r][1] <= col[r];
            end
        end
    end

    // window assembly and ring comparisons at PIX_W+1 bits
    always_comb begin
        col[0]  = lb_top[bx];
        col[1]  = lb_mid[bx];
        col[2]  = in_pixel;
        ring[0] = hist[0][0];
        ring[1] = hist[0][1];
        ring[2] = col[0];
        ring[3] = col[1];
        ring[4] = col[2];
        ring[5] = hist[2][1];
        ring[6] = hist[2][0];
        ring[7] = hist[1][0];
        centre  = hist[1][1];
        for (int i = 0; i < 8; i++) begin
            bright_c[i] = {1'b0, ring[i]} > ({1'b0, centre} + {1'b0, thr_q});
            dark_c[i]   = ({1'b0, ring[i]} + {1'b0, thr_q}) < {1'b0, centre};
        end
        // centre (bx-1, by-1) is interior exactly when bx>=2 and by>=2
        tok0 = accept && (bx >= X_W'(2)) && (by >= Y_W'(2));
    end

    // stage 1: comparison flags and centre coordinates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            lst_pipe[1] <= 1'b0;
            bright_q    <= '0;
            dark_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
        end else begin
            vld_pipe[1] <= tok0;
            lst_pipe[1] <= beat_last;
            bright_q    <= bright_c;
            dark_q      <= dark_c;
            cx_q        <= bx - X_W'(1);
            cy_q        <= by - Y_W'(1);
        end
    end

    always_comb begin
        hit_b = arc_found(bright_q);
        hit_d = arc_found(dark_q);
    end

    // stage 2: arc result and outputs; a sof beat discards the old frame's token
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            lst_pipe[2] <= 1'b0;
            bright_hit  <= 1'b0;
            dark_hit    <= 1'b0;
            kp_x        <= '0;
            kp_y        <= '0;
        end else begin
            vld_pipe[2] <= vld_pipe[1] && !sof_beat;
            lst_pipe[2] <= lst_pipe[1] && !sof_beat;
            bright_hit  <= hit_b;
            dark_hit    <= hit_d;
            if (vld_pipe[1] && !sof_beat && (hit_b || hit_d)) begin
                kp_x <= cx_q;
                kp_y <= cy_q;
            end
        end
    end

    assign kp_bright  = vld_pipe[2] & bright_hit;
    assign kp_dark    = vld_pipe[2] & dark_hit;
    assign kp_valid   = kp_bright | kp_dark;
    assign frame_done = lst_pipe[2];

endmodule

// File: tb/tb_fast_keypoint_stream.sv
// Scoreboard bench for fast_keypoint_stream on an 8x6 image. A reference
// model evaluates each driven beat from a copy of the frame and queues the
// expected result due two cycles later; outputs are compared every cycle.
// A second instance built with ARC_LEN=8 shares the stimulus.
module tb_fast_keypoint_stream;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int X_W   = 3;
    localparam int Y_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PIX_W-1:0] threshold, in_pixel;
    logic             in_valid, in_sof;
    logic             kp_valid, kp_bright, kp_dark, frame_done;
    logic [X_W-1:0]   kp_x;
    logic [Y_W-1:0]   kp_y;
    logic             kp_valid8, kp_bright8, kp_dark8, frame_done8;
    logic [X_W-1:0]   kp_x8;
    logic [Y_W-1:0]   kp_y8;

    always #5 clk = ~clk;

    fast_keypoint_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                           .ARC_LEN(4), .X_W(X_W), .Y_W(Y_W)) dut (
        .clk(clk), .rst_n(rst_n), .threshold(threshold), .in_valid(in_valid),
        .in_sof(in_sof), .in_pixel(in_pixel), .kp_valid(kp_valid),
        .kp_bright(kp_bright), .kp_dark(kp_dark), .kp_x(kp_x), .kp_y(kp_y),
        .frame_done(frame_done));

    fast_keypoint_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                           .ARC_LEN(8), .X_W(X_W), .Y_W(Y_W)) dut8 (
        .clk(clk), .rst_n(rst_n), .threshold(threshold), .in_valid(in_valid),
        .in_sof(in_sof), .in_pixel(in_pixel), .kp_valid(kp_valid8),
        .kp_bright(kp_bright8), .kp_dark(kp_dark8), .kp_x(kp_x8), .kp_y(kp_y8),
        .frame_done(frame_done8));

    typedef struct {
        int due;
        bit b;
        bit d;
        bit fd;
        int x;
        int y;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_err   = 0;
    int   last_x  = 0;
    int   last_y  = 0;
    int   rst_due = -1;
    int   mstate  = 0;
    int   mx      = 0;
    int   my      = 0;
    int   thr_lat = 0;
    int   dx [8]  = '{-1, 0, 1, 1, 1, 0, -1, -1};
    int   dy [8]  = '{-1, -1, -1, 0, 1, 1, 1, 0};
    logic [7:0] img [IMG_H][IMG_W];
    logic [7:0] pat [IMG_H][IMG_W];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit arc_model(input bit [7:0] v, input int len);
        int run;
        bit hit;
        run = 0;
        hit = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i % 8]) run++;
            else          run = 0;
            if (run >= len) hit = 1;
        end
        return hit;
    endfunction

    task automatic sample();
        exp_t e4, e8;
        e4 = '{due: 0, b: 0, d: 0, fd: 0, x: 0, y: 0};
        e8 = e4;
        if (q4.size() > 0 && q4[0].due == cyc) e4 = q4.pop_front();
        if (q8.size() > 0 && q8[0].due == cyc) e8 = q8.pop_front();
        if (cyc == rst_due) begin
            last_x = 0;
            last_y = 0;
        end
        if (e4.b || e4.d) begin
            last_x = e4.x;
            last_y = e4.y;
        end
        check("kp4_flags", {28'd0, kp_valid, kp_bright, kp_dark, frame_done},
              {28'd0, e4.b | e4.d, e4.b, e4.d, e4.fd});
        check("kp4_xy", 32'({kp_x, kp_y}), 32'((last_x << Y_W) | last_y));
        check("kp8_flags", {28'd0, kp_valid8, kp_bright8, kp_dark8, frame_done8},
              {28'd0, e8.b | e8.d, e8.b, e8.d, e8.fd});
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        sample();
    endtask

    // drop expectations that a sof or reset in this cycle must suppress
    task automatic kill_pending();
        while (q4.size() > 0 && q4[q4.size()-1].due >= cyc + 1) void'(q4.pop_back());
        while (q8.size() > 0 && q8[q8.size()-1].due >= cyc + 1) void'(q8.pop_back());
    endtask

    task automatic model_beat(input logic [7:0] pix, input bit sof);
        int   bx, by, cx, cy, p, c;
        bit [7:0] br, dk;
        bit   fd, b4, d4, b8, d8;
        exp_t e;
        if (sof) begin
            kill_pending();
            thr_lat = int'(threshold);
            mstate  = 1;
            bx = 0;
            by = 0;
        end else if (mstate == 0) begin
            return;
        end else begin
            bx = mx;
            by = my;
        end
        img[by][bx] = pix;
        fd = (bx == IMG_W - 1) && (by == IMG_H - 1);
        b4 = 0; d4 = 0; b8 = 0; d8 = 0;
        if (bx >= 2 && by >= 2) begin
            cx = bx - 1;
            cy = by - 1;
            c  = int'(img[cy][cx]);
            for (int i = 0; i < 8; i++) begin
                p     = int'(img[cy + dy[i]][cx + dx[i]]);
                br[i] = p > c + thr_lat;
                dk[i] = p + thr_lat < c;
            end
            b4 = arc_model(br, 4);
            d4 = arc_model(dk, 4);
            b8 = arc_model(br, 8);
            d8 = arc_model(dk, 8);
        end else begin
            cx = 0;
            cy = 0;
        end
        if (b4 || d4 || fd) begin
            e = '{due: cyc + 2, b: b4, d: d4, fd: fd, x: cx, y: cy};
            q4.push_back(e);
        end
        if (b8 || d8 || fd) begin
            e = '{due: cyc + 2, b: b8, d: d8, fd: fd, x: cx, y: cy};
            q8.push_back(e);
        end
        if (fd) begin
            mstate = 0;
            mx = 0;
            my = 0;
        end else if (bx == IMG_W - 1) begin
            mx = 0;
            my = by + 1;
        end else begin
            mx = bx + 1;
            my = by;
        end
    endtask

    task automatic step(input bit v, input bit sof, input logic [7:0] pix, input logic [7:0] thr);
        tick();
        in_valid  = v;
        in_sof    = sof;
        in_pixel  = pix;
        threshold = thr;
        if (v) model_beat(pix, sof);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), threshold);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) pat[y][x] = v;
    endtask

    task automatic setp(input int x, input int y, input logic [7:0] v);
        if (x >= 0 && x < IMG_W && y >= 0 && y < IMG_H) pat[y][x] = v;
    endtask

    // ring indices 0..3 (top-left, top, top-right, right) set to v
    task automatic arc_pat(input int cx, input int cy, input logic [7:0] v);
        setp(cx - 1, cy - 1, v);
        setp(cx,     cy - 1, v);
        setp(cx + 1, cy - 1, v);
        setp(cx + 1, cy,     v);
    endtask

    task automatic ring_pat(input int cx, input int cy, input logic [7:0] c, input logic [7:0] v);
        for (int i = 0; i < 8; i++) setp(cx + dx[i], cy + dy[i], v);
        setp(cx, cy, c);
    endtask

    // beats first..last of pat; sof on beat 0; threshold switches at chg_at
    task automatic send(input int first, input int last, input bit gaps,
                        input logic [7:0] thr, input int chg_at, input logic [7:0] chg_thr);
        for (int k = first; k <= last; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            step(1'b1, k == 0, pat[k / IMG_W][k % IMG_W],
                 (chg_at >= 0 && k >= chg_at) ? chg_thr : thr);
        end
    endtask

    task automatic frame(input bit gaps, input logic [7:0] thr);
        send(0, IMG_W * IMG_H - 1, gaps, thr, -1, 8'd0);
        idle(4);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; threshold = '0;
        // reset state
        step(1'b0, 1'b0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        idle(3);

        // flat frame: no keypoints, one frame_done
        fill(8'd100);                               frame(1'b0, 8'd7);
        // bright arc at (3,2), then just below threshold
        fill(8'd100); arc_pat(3, 2, 8'd108);        frame(1'b0, 8'd7);
        fill(8'd100); arc_pat(3, 2, 8'd107);        frame(1'b0, 8'd7);
        // dark arc wrapping indices 6,7,0,1; then just short
        fill(8'd100); setp(2, 3, 8'd92); setp(2, 2, 8'd92); setp(2, 1, 8'd92); setp(3, 1, 8'd92);
        frame(1'b0, 8'd7);
        fill(8'd100); setp(2, 3, 8'd93); setp(2, 2, 8'd93); setp(2, 1, 8'd93); setp(3, 1, 8'd93);
        frame(1'b0, 8'd7);
        // width extremes
        fill(8'd250); ring_pat(3, 2, 8'd250, 8'd255); frame(1'b0, 8'd7);
        fill(8'd3);   ring_pat(3, 2, 8'd3, 8'd0);     frame(1'b0, 8'd7);
        fill(8'd0);   ring_pat(3, 2, 8'd0, 8'd255);   frame(1'b0, 8'd7);
        // border centres, then the bright arc with input gaps
        fill(8'd100); arc_pat(0, 2, 8'd108);        frame(1'b0, 8'd7);
        fill(8'd100); arc_pat(3, 5, 8'd108);        frame(1'b0, 8'd7);
        fill(8'd100); arc_pat(3, 2, 8'd108);        frame(1'b1, 8'd7);

        // sof right after the beat completing a keypoint at (2,1)
        fill(8'd100); arc_pat(2, 1, 8'd108);
        send(0, 19, 1'b0, 8'd7, -1, 8'd0);
        fill(8'd100); arc_pat(3, 2, 8'd108);        frame(1'b0, 8'd7);

        // one-cycle reset mid-frame; the rest of the frame must be ignored
        fill(8'd100); arc_pat(2, 1, 8'd108);
        send(0, 19, 1'b0, 8'd7, -1, 8'd0);
        tick();
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        kill_pending();
        rst_due = cyc + 1;
        mstate = 0; mx = 0; my = 0; thr_lat = 0;
        tick();
        rst_n = 1'b1;
        fill(8'd100); arc_pat(3, 2, 8'd108);
        send(20, IMG_W * IMG_H - 1, 1'b0, 8'd7, -1, 8'd0);
        idle(4);
        frame(1'b0, 8'd7);

        // threshold lowered mid-frame has no effect until the next sof
        fill(8'd100); arc_pat(3, 2, 8'd107);
        send(0, IMG_W * IMG_H - 1, 1'b0, 8'd7, 10, 8'd0);
        idle(4);
        // the lowered threshold takes effect at the next sof
        frame(1'b0, 8'd0);

        idle(4);
        check("queue_drained", 32'(q4.size() + q8.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
